// File: rtl/controle_pkg.sv
// Shared types for the sequence controller: state codes and output bundle.
// The state code doubles as the 7-segment debug value.
package controle_pkg;

  localparam int TIMEOUT_CICLOS_PADRAO = 5000;

  typedef enum logic [4:0] {
    inicial     = 5'd0,
    preparacao  = 5'd1,
    espera      = 5'd2,
    registra    = 5'd4,
    comparacao  = 5'd5,
    proximo     = 5'd6,
    fim_acertou = 5'd10,
    fim_errou   = 5'd14,
    fim_timeout = 5'd15
  } estado_t;

  typedef struct packed {
    logic zera_c;
    logic conta_c;
    logic zera_r;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  function automatic saidas_t decodifica(estado_t e);
    saidas_t s;
    s = '0;
    s.zera_c     = (e != preparacao);
    s.zera_r     = (e == preparacao);
    s.registra_r = (e == registra);
    s.conta_c    = (e == proximo);
    s.acertou    = (e == fim_acertou);
    s.errou      = (e == fim_errou);
    s.timeout    = (e == fim_timeout);
    s.pronto     = s.acertou | s.errou | s.timeout;
    return s;
  endfunction

endpackage

// File: rtl/controle_sequencia_contador_timeout.sv
// Modulo-M inactivity counter; zera is an active-low synchronous clear.
// fim is high while the count sits at M-1.
module contador_timeout #(
  parameter int M = 5000
) (
  input  logic clock,
  input  logic clr,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] q;

  assign fim = (q == W'(M - 1));

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      q <= '0;
    end else if (!zera) begin
      q <= '0;
    end else if (conta) begin
      q <= fim ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/controle_sequencia.sv
// Round controller for the sequence game; optional inactivity timeout
// is compiled in with TIMEOUT_EN.
module controle_sequencia
  import controle_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [4:0] db_estado
);

  estado_t estado;
  estado_t prox;
  saidas_t saidas;
  logic    fim_timer;

`ifdef TIMEOUT_EN
  logic em_espera;

  assign em_espera = (estado == espera);

  contador_timeout #(
    .M(TIMEOUT_CICLOS)
  ) u_timer (
    .clock(clock),
    .clr  (clr),
    .zera (em_espera),
    .conta(em_espera),
    .fim  (fim_timer)
  );
`else
  assign fim_timer = 1'b0;
`endif

  always_comb begin
    prox = estado;
    unique case (estado)
      inicial:
        if (iniciar) prox = preparacao;
      preparacao:
        prox = espera;
      espera:
        if (jogada)         prox = registra;
        else if (fim_timer) prox = fim_timeout;
      registra:
        prox = comparacao;
      comparacao:
        if (!igual)    prox = fim_errou;
        else if (fimC) prox = fim_acertou;
        else           prox = proximo;
      proximo:
        prox = espera;
      fim_acertou, fim_errou, fim_timeout:
        if (iniciar) prox = preparacao;
      default:
        prox = inicial;
    endcase
  end

  // Outputs are registered from the next state so they stay Moore and glitch-free.
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      estado <= inicial;
      saidas <= decodifica(inicial);
    end else begin
      estado <= prox;
      saidas <= decodifica(prox);
    end
  end

  assign zeraC     = saidas.zera_c;
  assign contaC    = saidas.conta_c;
  assign zeraR     = saidas.zera_r;
  assign registraR = saidas.registra_r;
  assign pronto    = saidas.pronto;
  assign acertou   = saidas.acertou;
  assign errou     = saidas.errou;
  assign timeout   = saidas.timeout;
  assign db_estado = estado;

endmodule

// File: tb/tb_controle_sequencia.sv
// Scoreboard bench for controle_sequencia: stimulus pushes expected
// events, a negedge monitor pops them as the DUT strobes.
module tb_controle_sequencia;

`ifdef TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 5000;
`endif

  logic       clock = 1'b0;
  logic       clr = 1'b1;
  logic       iniciar = 1'b0;
  logic       jogada = 1'b0;
  logic       igual = 1'b0;
  logic       fimC = 1'b0;
  logic       zeraC, contaC, zeraR, registraR;
  logic       pronto, acertou, errou, timeout;
  logic [4:0] db_estado;

  int checks = 0;
  int errors = 0;

  // event codes: 0 prep, 1 register, 2 count, 3 win, 4 lose, 5 timeout
  int exp_q[$];
  int conta_pulsos = 0;
  logic pronto_ant = 1'b0;

  // reference model of the round, in edge indices
  int  k = 0;
  bit  ativo = 0;
  int  inicia_em = 0;
  int  aceita_em = 0;
  int  movs = 0;
  int  comprimento = 1;
  int  erro_em = 0;
  int  exp_conta = 0;
  int  resultado = 0;

  controle_sequencia #(.TIMEOUT_CICLOS(TO)) dut (
    .clock    (clock),
    .clr      (clr),
    .iniciar  (iniciar),
    .jogada   (jogada),
    .igual    (igual),
    .fimC     (fimC),
    .zeraC    (zeraC),
    .contaC   (contaC),
    .zeraR    (zeraR),
    .registraR(registraR),
    .pronto   (pronto),
    .acertou  (acertou),
    .errou    (errou),
    .timeout  (timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int db_de(int c);
    case (c)
      0: return 1;
      1: return 4;
      2: return 6;
      3: return 10;
      4: return 14;
      default: return 15;
    endcase
  endfunction

  task automatic evento(int c);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL evento unexpected actual=%0d required=none", c);
    end else begin
      e = exp_q.pop_front();
      chk("evento", c, e);
      chk("evento_db", db_estado, db_de(e));
    end
  endtask

  always @(negedge clock) begin
    if (clr === 1'b1) begin
      if (zeraC === 1'b0) begin
        evento(0);
        chk("zeraR_prep", zeraR, 1);
      end
      if (registraR === 1'b1) evento(1);
      if (contaC === 1'b1) begin
        evento(2);
        conta_pulsos++;
      end
      if (pronto === 1'b1 && pronto_ant !== 1'b1)
        evento(acertou ? 3 : errou ? 4 : timeout ? 5 : 6);
    end
    pronto_ant = pronto;
  end

  task automatic passo(bit jog, bit ini);
    bit mv, st;
    st = ini && !ativo && (k >= inicia_em);
    mv = jog && ativo && (k >= aceita_em);
    if (st) begin
      exp_q.push_back(0);
      ativo = 1;
      aceita_em = k + 2;
      movs = 0;
      exp_conta = 0;
      conta_pulsos = 0;
    end
    if (mv) begin
      movs++;
      igual = (movs != erro_em);
      fimC = (movs == comprimento);
      exp_q.push_back(1);
      if (!igual || fimC) begin
        resultado = igual ? 3 : 4;
        exp_q.push_back(resultado);
        ativo = 0;
        inicia_em = k + 3;
      end else begin
        exp_q.push_back(2);
        exp_conta++;
        aceita_em = k + 4;
      end
    end
    jogada = jog;
    iniciar = ini;
    @(posedge clock);
    k++;
    #1;
    jogada = 1'b0;
    iniciar = 1'b0;
  endtask

  task automatic rodada(int len, int err_at, bit ruido);
    int g;
    bit j, i;
    comprimento = len;
    erro_em = err_at;
    g = 0;
    while (!ativo && g < 50) begin
      passo(ruido ? 1'($urandom_range(0, 1)) : 1'b0, k >= inicia_em);
      g++;
    end
    g = 0;
    while (ativo && g < 300) begin
      if (k >= aceita_em)
        j = (k >= aceita_em + 2) ? 1'b1 : 1'($urandom_range(0, 1));
      else
        j = ruido ? 1'($urandom_range(0, 1)) : 1'b0;
      i = ruido ? ($urandom_range(0, 3) == 0) : 1'b0;
      passo(j, i);
      g++;
    end
    if (ativo) begin
      checks++;
      errors++;
      $display("FAIL rodada_budget actual=active required=ended");
      ativo = 0;
    end
    repeat (3) passo(0, 0);
    chk("contaC_count", conta_pulsos, exp_conta);
    chk("pronto_end", pronto, 1);
    chk("acertou_end", acertou, resultado == 3);
    chk("errou_end", errou, resultado == 4);
    chk("timeout_end", timeout, 0);
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_db"}, db_estado, 0);
    chk({nm, "_zeraC"}, zeraC, 1);
    chk({nm, "_strobes"}, {contaC, zeraR, registraR}, 0);
    chk({nm, "_flags"}, {pronto, acertou, errou, timeout}, 0);
  endtask

  initial begin
    int len;
    #2 clr = 1'b0;
    #1 chk_reset("reset_async");
    @(posedge clock);
    @(posedge clock);
    #1 chk_reset("reset_held");
    clr = 1'b1;
    k = 0;
    inicia_em = 0;

    // start sequence 0,1,2 then nine correct moves
    passo(0, 0);
    chk("start_db0", db_estado, 0);
    comprimento = 9;
    erro_em = 0;
    passo(0, 1);
    chk("start_db1", db_estado, 1);
    chk("start_zeraC0", zeraC, 0);
    passo(0, 0);
    chk("start_db2", db_estado, 2);
    chk("start_zeraC1", zeraC, 1);
    rodada(9, 0, 0);
    chk("nine_moves_conta", conta_pulsos, 8);
    passo(0, 0);
    chk("conta_idle_after_win", contaC, 0);

    rodada(5, 3, 0);
    chk("err3_conta", conta_pulsos, 2);

    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 9);
      rodada(len, ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0, 1);
    end

    // asynchronous clear while in comparacao
    comprimento = 9;
    erro_em = 0;
    while (!ativo) passo(0, 1);
    while (k < aceita_em) passo(0, 0);
    passo(1, 0);
    passo(0, 0);
    chk("pre_clr_db", db_estado, 5);
    #2 clr = 1'b0;
    #1 chk_reset("mid_clr");
    exp_q.delete();
    ativo = 0;
    @(posedge clock);
    k++;
    #1 chk_reset("mid_clr_held");
    clr = 1'b1;
    inicia_em = k;
    rodada(4, 0, 0);
    chk("after_clr_conta", conta_pulsos, 3);

    // inactivity in espera
    comprimento = 9;
    erro_em = 0;
    while (!ativo) passo(0, 1);
    passo(0, 0);
    chk("idle_db_espera", db_estado, 2);
`ifdef TIMEOUT_EN
    exp_q.push_back(5);
    repeat (7) passo(0, 0);
    chk("to_db_before", db_estado, 2);
    passo(0, 0);
    chk("to_db", db_estado, 15);
    chk("to_flag", timeout, 1);
    chk("to_pronto", pronto, 1);
    ativo = 0;
    inicia_em = k;
    repeat (2) passo(0, 0);
`else
    repeat (40) passo(0, 0);
    chk("no_to_db", db_estado, 2);
    chk("no_to_flag", timeout, 0);
    chk("no_to_pronto", pronto, 0);
`endif
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
